// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB branch predictor with saturating counters and 1-cycle redirect.
// Define BRANCH_PREDICT_STATS_EN to add stat_resolved / stat_mispredict outputs.
module branch_predict_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  resolve_valid,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic                  resolve_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  input  logic                  resolve_pred_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_pred_target,
  input  logic                  stall,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0]           stat_resolved,
  output logic [31:0]           stat_mispredict
`endif
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_WT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic [BTB_DEPTH-1:0] vld_q;
  logic [TAG_W-1:0]      tag_q [BTB_DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_q [BTB_DEPTH];
  logic [CNT_WIDTH-1:0]  cnt_q [BTB_DEPTH];

  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic             fhit;
  logic [IDX_W-1:0] ridx;
  logic [TAG_W-1:0] rtag;
  logic             rhit;
  logic             accept;
  logic             mispredict;
  logic [CNT_WIDTH-1:0] rcnt;

  assign fidx = fetch_pc[IDX_W+1:2];
  assign ftag = fetch_pc[ADDR_WIDTH-1:IDX_W+2];
  assign fhit = vld_q[fidx] && (tag_q[fidx] == ftag);

  always_comb begin
    pred_taken  = fhit && cnt_q[fidx][CNT_WIDTH-1];
    pred_target = fetch_pc + ADDR_WIDTH'(4);
    if (pred_taken) pred_target = tgt_q[fidx];
  end

  assign ridx   = resolve_pc[IDX_W+1:2];
  assign rtag   = resolve_pc[ADDR_WIDTH-1:IDX_W+2];
  assign rhit   = vld_q[ridx] && (tag_q[ridx] == rtag);
  assign rcnt   = cnt_q[ridx];
  assign accept = resolve_valid && !stall;

  assign mispredict = accept &&
    ((resolve_taken != resolve_pred_taken) ||
     (resolve_taken && (resolve_target != resolve_pred_target)));

  // Stall freezes the pending redirect; a newer mispredict overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= PC_ADDR;
    end else if (!stall) begin
      flush          <= mispredict;
      redirect_valid <= mispredict;
      if (mispredict)
        redirect_pc <= resolve_taken ? resolve_target
                                     : resolve_pc + ADDR_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) cnt_q[i] <= CNT_WNT;
    end else if (accept) begin
      if (resolve_taken) begin
        vld_q[ridx] <= 1'b1;
        if (!rhit)               cnt_q[ridx] <= CNT_WT;
        else if (rcnt != CNT_MAX) cnt_q[ridx] <= rcnt + CNT_WIDTH'(1);
      end else if (rhit && (rcnt != '0)) begin
        cnt_q[ridx] <= rcnt - CNT_WIDTH'(1);
      end
    end
  end

  // Tag and target need no reset: they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (accept && resolve_taken) begin
      tag_q[ridx] <= rtag;
      tgt_q[ridx] <= resolve_target;
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_resolved   <= '0;
      stat_mispredict <= '0;
    end else begin
      if (accept)     stat_resolved   <= stat_resolved + 32'd1;
      if (mispredict) stat_mispredict <= stat_mispredict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vectors, behavioural BTB model,
// per-cycle output comparison plus hand-computed literal checks.
module tb_branch_predict_unit;

  localparam int DEPTH = 16;
  localparam int CMAX  = 3;
  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispredict;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_pc            (fetch_pc),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .stall               (stall),
    .flush               (flush),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc)
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    .stat_resolved       (stat_resolved),
    .stat_mispredict     (stat_mispredict)
`endif
  );

  // Behavioural model: per-index entry keyed by pc/4 mod DEPTH, tag pc/(4*DEPTH).
  bit          m_v   [DEPTH];
  logic [31:0] m_tag [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  int          m_cnt [DEPTH];
  bit          m_flush;
  logic [31:0] m_rpc;
  logic [31:0] m_res;
  logic [31:0] m_mis;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    int i = midx(pc);
    return m_v[i] && (m_tag[i] == pc / (4 * DEPTH));
  endfunction

  always @(posedge clk or posedge reset) begin
    automatic int  i;
    automatic bit  mis;
    if (reset) begin
      m_flush <= 1'b0;
      m_rpc   <= PC0;
      m_res   <= '0;
      m_mis   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        m_v[k]   <= 1'b0;
        m_cnt[k] <= 1;
      end
    end else if (!stall) begin
      mis = resolve_valid &&
            (resolve_taken != resolve_pred_taken ||
             (resolve_taken && resolve_target != resolve_pred_target));
      m_flush <= mis;
      if (mis) begin
        m_rpc <= resolve_taken ? resolve_target : resolve_pc + 4;
        m_mis <= m_mis + 1;
      end
      if (resolve_valid) begin
        m_res <= m_res + 1;
        i = midx(resolve_pc);
        if (resolve_taken) begin
          m_cnt[i] <= mhit(resolve_pc) ? ((m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX) : 2;
          m_v[i]   <= 1'b1;
          m_tag[i] <= resolve_pc / (4 * DEPTH);
          m_tgt[i] <= resolve_target;
        end else if (mhit(resolve_pc)) begin
          m_cnt[i] <= (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    automatic bit          et;
    automatic logic [31:0] eg;
    if (chk_en && !reset) begin
      et = mhit(fetch_pc) && (m_cnt[midx(fetch_pc)] >= 2);
      eg = et ? m_tgt[midx(fetch_pc)] : fetch_pc + 4;
      chk("m_pred_taken", 32'(pred_taken), 32'(et));
      chk("m_pred_target", pred_target, eg);
      chk("m_flush", 32'(flush), 32'(m_flush));
      chk("m_redirect_valid", 32'(redirect_valid), 32'(m_flush));
      chk("m_redirect_pc", redirect_pc, m_rpc);
`ifdef BRANCH_PREDICT_STATS_EN
      chk("m_stat_resolved", stat_resolved, m_res);
      chk("m_stat_mispredict", stat_mispredict, m_mis);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic res(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    resolve_valid       = 1'b1;
    resolve_pc          = pc;
    resolve_taken       = t;
    resolve_target      = tg;
    resolve_pred_taken  = pt;
    resolve_pred_target = ptg;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
    stall         = 1'b0;
  endtask

  task automatic chk_redir(input string nm, input logic f, input logic [31:0] pc);
    chk({nm, "_flush"}, 32'(flush), 32'(f));
    chk({nm, "_rv"}, 32'(redirect_valid), 32'(f));
    chk({nm, "_rpc"}, redirect_pc, pc);
  endtask

  task automatic chk_pred(input string nm, input logic t, input logic [31:0] tg);
    chk({nm, "_pt"}, 32'(pred_taken), 32'(t));
    chk({nm, "_ptgt"}, pred_target, tg);
  endtask

  initial begin
    stall = 1'b0;
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_taken = 1'b0;
    resolve_target = '0;
    resolve_pred_taken = 1'b0;
    resolve_pred_target = '0;
    fetch_pc = 32'h8000_0010;
    repeat (3) step();
    chk_redir("reset", 1'b0, PC0);
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk_pred("cold", 1'b0, 32'h8000_0014);

    // First taken resolve allocates and redirects
    res(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0014);
    step();
    chk_redir("alloc", 1'b1, 32'h8000_0100);
    chk_pred("alloc", 1'b1, 32'h8000_0100);
    idle();
    step();
    chk_redir("pulse_end", 1'b0, 32'h8000_0100);

    // Two not-taken resolves train the counter down
    res(32'h8000_0010, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0100);
    step();
    chk_redir("nt1", 1'b1, 32'h8000_0014);
    chk_pred("nt1", 1'b0, 32'h8000_0014);
    res(32'h8000_0010, 1'b0, 32'h8000_0100, 1'b0, 32'h8000_0014);
    step();
    chk_redir("nt2", 1'b0, 32'h8000_0014);

    // Correct predictions; same-cycle lookup sees old counter
    res(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);
    step();
    chk_redir("ok1", 1'b0, 32'h8000_0014);
    chk_pred("ok1", 1'b0, 32'h8000_0014);
    res(32'h8000_0010, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0100);
    #1;
    chk_pred("preupd", 1'b0, 32'h8000_0014);
    step();
    chk_pred("postupd", 1'b1, 32'h8000_0100);
    chk_redir("ok2", 1'b0, 32'h8000_0014);

    // Aliasing replaces index 4
    res(32'h8000_0050, 1'b1, 32'h8000_0200, 1'b0, 32'h8000_0054);
    step();
    chk_redir("alias", 1'b1, 32'h8000_0200);
    chk_pred("alias_old", 1'b0, 32'h8000_0014);
    fetch_pc = 32'h8000_0050;
    #1;
    chk_pred("alias_new", 1'b1, 32'h8000_0200);

    // Wrong target while a redirect is still being output
    res(32'h8000_0050, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0200);
    step();
    chk_redir("tgt_mis", 1'b1, 32'h8000_0300);
    chk_pred("tgt_mis", 1'b1, 32'h8000_0300);

    // Back-to-back mispredicts overwrite redirect_pc
    res(32'h8000_0020, 1'b1, 32'h8000_0400, 1'b0, 32'h8000_0024);
    step();
    chk_redir("b2b1", 1'b1, 32'h8000_0400);
    res(32'h8000_0030, 1'b0, 32'h0, 1'b1, 32'h8000_0034);
    step();
    chk_redir("b2b2", 1'b1, 32'h8000_0034);
    idle();
    step();
    chk_redir("b2b_end", 1'b0, 32'h8000_0034);

    // Stall holds a pending redirect and ignores resolves
    res(32'h8000_0060, 1'b1, 32'h8000_0600, 1'b0, 32'h8000_0064);
    step();
    chk_redir("pre_stall", 1'b1, 32'h8000_0600);
    stall = 1'b1;
    res(32'h8000_0070, 1'b1, 32'h8000_0700, 1'b0, 32'h8000_0074);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_redir("stall_hold", 1'b1, 32'h8000_0600);
    end
    fetch_pc = 32'h8000_0070;
    #1;
    chk_pred("stall_noupd", 1'b0, 32'h8000_0074);
    idle();
    step();
    chk_redir("stall_end", 1'b0, 32'h8000_0600);
    stall = 1'b1;
    res(32'h8000_0070, 1'b1, 32'h8000_0700, 1'b0, 32'h8000_0074);
    repeat (2) begin
      step();
      chk_redir("stall_ign", 1'b0, 32'h8000_0600);
    end
    idle();
    fetch_pc = 32'h8000_0050;
    step();

    // Saturation at all-ones, then one decrement still predicts taken
    res(32'h8000_0050, 1'b1, 32'h8000_0300, 1'b1, 32'h8000_0300);
    step();
    chk_redir("sat", 1'b0, 32'h8000_0600);
    res(32'h8000_0050, 1'b0, 32'h8000_0300, 1'b1, 32'h8000_0300);
    step();
    chk_redir("sat_dec", 1'b1, 32'h8000_0054);
    chk_pred("sat_dec", 1'b1, 32'h8000_0300);
    idle();

    // Reset in the middle of a flush pulse
    reset = 1'b1;
    #1;
    chk_redir("mid_rst", 1'b0, PC0);
    chk_pred("mid_rst", 1'b0, 32'h8000_0054);
    step();
    reset = 1'b0;
    res(32'h8000_0080, 1'b1, 32'h8000_0800, 1'b0, 32'h8000_0084);
    step();
    chk_redir("post_rst", 1'b1, 32'h8000_0800);
    idle();
    fetch_pc = 32'h8000_0080;
    step();
    chk_pred("post_rst", 1'b1, 32'h8000_0800);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter PC_ADDR, 32'h8000_0000, reset value of redirect_pc.
REQ-002 Parameter ADDR_WIDTH, 32, PC and target width.
REQ-003 Parameter BTB_DEPTH, 16, BTB entries; power of two, at least 2.
REQ-004 Parameter CNT_WIDTH, 2, width of the saturating direction counter per entry.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 fetch_pc  in  ADDR_WIDTH  PC being fetched this cycle.
REQ-008 pred_taken  out  1  prediction for fetch_pc, taken.
REQ-009 pred_target  out  ADDR_WIDTH  predicted next PC for fetch_pc.
REQ-010 resolve_valid  in  1  a branch or jump resolves in EX this cycle.
REQ-011 resolve_pc  in  ADDR_WIDTH  PC of the resolving instruction.
REQ-012 resolve_taken  in  1  actual direction.
REQ-013 resolve_target  in  ADDR_WIDTH  actual taken target.
REQ-014 resolve_pred_taken  in  1  prediction carried down the pipe.
REQ-015 resolve_pred_target  in  ADDR_WIDTH  prediction carried down the pipe.
REQ-016 stall  in  1  pipeline stalled; holds a pending redirect.
REQ-017 flush  out  1  invalidate IF/ID instructions.
REQ-018 redirect_valid  out  1  PC must load redirect_pc.
REQ-019 redirect_pc  out  ADDR_WIDTH  corrected PC.

Function
REQ-020 Index is pc[log2(BTB_DEPTH)+1:2]; tag is pc[ADDR_WIDTH-1:log2(BTB_DEPTH)+2].
REQ-021 Each entry holds valid, tag, target and a CNT_WIDTH-bit counter.
REQ-022 Lookup is combinational from registered state.
  - Hit (valid and tag match) with counter MSB = 1: pred_taken=1, pred_target=stored target.
  - Otherwise: pred_taken=0, pred_target=fetch_pc+4 (mod 2^ADDR_WIDTH).
REQ-023 A mispredict is resolve_valid with either of:
  - resolve_taken != resolve_pred_taken;
  - both taken and resolve_target != resolve_pred_target.
REQ-024 Mispredict latency is 1 cycle: on the next edge flush=1, redirect_valid=1, and redirect_pc is set.
  - redirect_pc = resolve_target if resolve_taken, else resolve_pc+4.
REQ-025 Redirect with stall=0 is a single-cycle pulse; flush and redirect_valid return to 0 on the following edge unless another mispredict occurs.
REQ-026 While stall=1, flush, redirect_valid and redirect_pc hold their values.
  - resolve_valid is ignored: no mispredict detection and no table update.
REQ-027 A correct prediction produces no flush; redirect_pc stays unchanged.
REQ-028 Update on every accepted resolve_valid:
  - Taken: write valid=1, tag, target; increment counter, saturating at all-ones.
  - Not-taken on a hit: decrement counter, saturating at 0.
  - Not-taken on a miss: no write.
REQ-029 A taken resolve that misses (or hits a tag mismatch) allocates the entry by replacement and sets its counter to weakly-taken, MSB=1 and rest 0.
REQ-030 When lookup and update hit the same index in one cycle, lookup returns the pre-update value; the new value is visible the next cycle.
REQ-031 A mispredict arriving while a redirect is being output (stall=0) overwrites redirect_pc with the newer value, and flush stays high.

Reset
REQ-032 Reset asserted at any time, including mid-redirect, takes effect immediately:
  - flush=0, redirect_valid=0, redirect_pc=PC_ADDR;
  - all valid bits 0 and all counters weakly-not-taken (MSB=0, LSB=1);
  - statistics counters 0.
REQ-033 Outputs are defined on the first edge after reset deasserts; no resolve is lost after deassertion.

Configuration
REQ-034 Macro BRANCH_PREDICT_STATS_EN, when defined, adds two outputs:
  - stat_resolved (32 bits), incremented per accepted resolve;
  - stat_mispredict (32 bits), incremented per mispredict.
  - Both wrap at 2^32.
REQ-035 When BRANCH_PREDICT_STATS_EN is undefined, those ports and counters do not exist; all other behaviour is identical.

Verification
REQ-036 Reset, then fetch_pc=0x8000_0010 -> pred_taken=0, pred_target=0x8000_0014, flush=0, redirect_pc=0x8000_0000.
REQ-037 Resolve pc=0x8000_0010 taken, target=0x8000_0100, pred_taken=0 -> next cycle flush=1, redirect_pc=0x8000_0100; the cycle after, flush=0; fetch 0x8000_0010 now predicts taken to 0x8000_0100.
REQ-038 Two not-taken resolves of 0x8000_0010 after REQ-037 -> first gives a mispredict with redirect_pc=0x8000_0014 (counter 10 to 01); lookup then predicts not-taken.
REQ-039 Aliasing: taken resolve of 0x8000_0050 with BTB_DEPTH=16 -> replaces the index-4 entry; fetch 0x8000_0010 then misses.
REQ-040 Mispredict with stall=1 held 3 cycles -> no flush during stall; a mispredict accepted just before the stall holds flush=1 and redirect_pc stable for all 3 cycles.
REQ-041 Reset asserted during a flush pulse -> flush=0 and redirect_pc=0x8000_0000 immediately; a prior BTB hit becomes a miss.
